// File: rtl/timestamp_image_mem.sv
// Per-pixel {timestamp, polarity} image with a dual-read / port-1-write request interface.
// A zeroing sweep runs after every reset; requests are accepted only once it completes.
module timestamp_image_mem #(
    parameter int unsigned DVS_WIDTH       = 346,
    parameter int unsigned DVS_HEIGHT      = 260,
    parameter int unsigned WORD_SIZE       = 18,
    parameter int unsigned CAVIAR_X_Y_BITS = 9,
    parameter int unsigned TIMESTAMP_BITS  = 16,
    parameter int unsigned POLARITY_BITS   = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cen,
    input  logic                       rw,
    input  logic [CAVIAR_X_Y_BITS-1:0] addr_port1_x,
    input  logic [CAVIAR_X_Y_BITS-1:0] addr_port1_y,
    input  logic [CAVIAR_X_Y_BITS-1:0] addr_port2_x,
    input  logic [CAVIAR_X_Y_BITS-1:0] addr_port2_y,
    input  logic [WORD_SIZE-1:0]       write_data_mem,
    output logic [WORD_SIZE-1:0]       read_data1_mem,
    output logic [WORD_SIZE-1:0]       read_data2_mem,
    output logic                       read_data_mem_vld1,
    output logic                       read_data_mem_vld2,
    output logic                       mem_ready,
    output logic                       oob_err
);

    localparam int unsigned Depth = DVS_WIDTH * DVS_HEIGHT;
    localparam int unsigned IdxW  = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(Depth - 1);

    if (WORD_SIZE != TIMESTAMP_BITS + POLARITY_BITS) begin : g_word_size_check
        $error("WORD_SIZE must equal TIMESTAMP_BITS + POLARITY_BITS");
    end

    typedef enum logic {StClear, StReady} state_e;

    state_e              state_q, state_d;
    logic [IdxW-1:0]     cnt_q, cnt_d;
    logic [WORD_SIZE-1:0] mem_q [Depth];

    logic [WORD_SIZE-1:0] rd1_q, rd1_d, rd2_q, rd2_d;
    logic                 vld_q, vld_d, oob_q, oob_d;

    logic [31:0]     lin1, lin2;
    logic [IdxW-1:0] idx1, idx2;
    logic            in1, in2, accept, rd_req, wr_req;
    logic [WORD_SIZE-1:0] rd1, rd2;
    logic            unused_lin;

    // Full-width linear index; only the low bits are needed once the range check passes.
    assign lin1 = 32'(addr_port1_x) * DVS_HEIGHT + 32'(addr_port1_y);
    assign lin2 = 32'(addr_port2_x) * DVS_HEIGHT + 32'(addr_port2_y);
    assign idx1 = lin1[IdxW-1:0];
    assign idx2 = lin2[IdxW-1:0];
    assign unused_lin = ^{lin1[31:IdxW], lin2[31:IdxW]};

    assign in1 = (32'(addr_port1_x) < DVS_WIDTH) && (32'(addr_port1_y) < DVS_HEIGHT);
    assign in2 = (32'(addr_port2_x) < DVS_WIDTH) && (32'(addr_port2_y) < DVS_HEIGHT);

    assign accept = (state_q == StReady) && cen;
    assign rd_req = accept && !rw;
    assign wr_req = accept && rw && in1;
    assign rd1    = in1 ? mem_q[idx1] : '0;
    assign rd2    = in2 ? mem_q[idx2] : '0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StClear: begin
                if (cnt_q == LastIdx) begin
                    state_d = StReady;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StReady: state_d = StReady;
            default: state_d = StClear;
        endcase
    end

    always_comb begin
        rd1_d = rd1_q;
        rd2_d = rd2_q;
        vld_d = rd_req;
        oob_d = accept && (!in1 || (!rw && !in2));
        if (rd_req) begin
            rd1_d = rd1;
            rd2_d = rd2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StClear;
            cnt_q   <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            vld_q   <= 1'b0;
            oob_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            vld_q   <= vld_d;
            oob_q   <= oob_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == StClear) begin
                mem_q[cnt_q] <= '0;
            end else if (wr_req) begin
                mem_q[idx1] <= write_data_mem;
            end
        end
    end

    assign read_data1_mem     = rd1_q;
    assign read_data2_mem     = rd2_q;
    assign read_data_mem_vld1 = vld_q;
    assign read_data_mem_vld2 = vld_q;
    assign mem_ready          = (state_q == StReady);
    assign oob_err            = oob_q;

endmodule

// File: doc/timestamp_image_mem.md
# timestamp_image_mem

Responder for the timestamp-image memory interface driven by `create_mlp_activations`. It holds one WORD_SIZE word per DVS pixel, in the form {timestamp, polarity}. The block serves dual-port reads and port-1 writes under the `cen`/`rw` protocol, with registered one-cycle read latency. After every reset it runs a clearing sweep and reports `mem_ready` once the image is all zeros, so the activation builder never sees stale timestamps.

## Interface
Parameters:
- DVS_WIDTH, 346, number of x positions.
- DVS_HEIGHT, 260, number of y positions.
- WORD_SIZE, 18, stored word width; must equal TIMESTAMP_BITS + POLARITY_BITS.
- CAVIAR_X_Y_BITS, 9, width of each x/y address field.
- TIMESTAMP_BITS, 16, timestamp field width, occupying word bits [WORD_SIZE-1:POLARITY_BITS].
- POLARITY_BITS, 2, polarity field width, occupying word bits [POLARITY_BITS-1:0].

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- cen  in  1  request enable.
- rw  in  1  0 = read, 1 = write; sampled only when `cen`=1.
- addr_port1_x, addr_port1_y  in  CAVIAR_X_Y_BITS each  port-1 address; used for both read and write.
- addr_port2_x, addr_port2_y  in  CAVIAR_X_Y_BITS each  port-2 read address.
- write_data_mem  in  WORD_SIZE  write data for port 1.
- read_data1_mem, read_data2_mem  out  WORD_SIZE  registered read data.
- read_data_mem_vld1, read_data_mem_vld2  out  1  read-data valid strobes.
- mem_ready  out  1  clearing sweep done; requests are accepted.
- oob_err  out  1  one-cycle pulse when a request carries an out-of-range address.

## Operation
- Addressing: linear index = x*DVS_HEIGHT + y. An address is in range iff x < DVS_WIDTH and y < DVS_HEIGHT.
- FSM states: CLEAR and READY.
  - `rst` forces CLEAR and sets the sweep counter to 0.
  - CLEAR writes 0 to the location at the counter, one location per cycle, and increments the counter.
  - After location DVS_WIDTH*DVS_HEIGHT-1 is written, the FSM moves to READY.
  - READY is held until the next `rst`.
- In CLEAR, `mem_ready`=0 and all requests are ignored: no vld, no write, no `oob_err`.
- Read request (READY, `cen`=1, `rw`=0):
  - Both ports are read in the same cycle.
  - Each port's data and vld (=1) are registered for the next cycle.
  - An out-of-range port returns 0 with vld=1 and `oob_err` pulses.
- Write request (READY, `cen`=1, `rw`=1):
  - `write_data_mem` is stored at the port-1 address.
  - Both vld outputs go 0 on the next edge.
  - An out-of-range address suppresses the write and pulses `oob_err`.
- Idle (`cen`=0): both vld outputs go 0; the data registers hold their last value.
- Ports 1 and 2 may address the same location; both return the same word.
- Arithmetic:
  - The sweep counter is ceil(log2(DVS_WIDTH*DVS_HEIGHT)) bits and never wraps past the last index.
  - The linear index is computed at full width, with no truncation of x*DVS_HEIGHT.

## Timing
- Reset values: `read_data1_mem`=0, `read_data2_mem`=0, both vld=0, `mem_ready`=0, `oob_err`=0.
- Clear duration: the first cycle after `rst` deasserts is sweep index 0. `mem_ready` rises exactly DVS_WIDTH*DVS_HEIGHT cycles after that cycle.
- Read latency: request at edge N, data and vld valid after edge N+1. Vld holds 1 for each consecutive read-request cycle, so back-to-back reads give one result per cycle.
- Write→read: write at edge N, then a read of the same address at edge N+1 returns the new data after edge N+2. There is no stale-data window.
- `oob_err` is registered and asserted for the cycle following the offending request.
- A read or write request in the same cycle as `mem_ready` rising is still ignored. Requests are first accepted on the edge after `mem_ready` is observed high.
- `rst` mid-sweep or mid-READY:
  - all outputs return to reset values on that edge;
  - the sweep restarts from index 0;
  - memory contents are re-zeroed by the new sweep.
- `rw` is don't-care when `cen`=0.

## Test plan
Use DVS_WIDTH=8 and DVS_HEIGHT=8 unless stated otherwise.
- Reset then idle → `mem_ready` low for exactly 64 cycles after `rst` deasserts, then high. Reads of (0,0) and (7,7) return 0 with both vld=1.
- Write 18'h00C81 at (3,5), then next cycle read port1=(3,5), port2=(5,3) → `read_data1_mem`=18'h00C81, `read_data2_mem`=0, both vld=1 one cycle after the read.
- Four back-to-back reads of (1,1)…(4,4) after writing x+y into each → data 2, 4, 6, 8 on four consecutive cycles with vld held high. A following `cen`=0 cycle gives vld=0.
- Write at (9,2), then read port1=(2,9) → the write is dropped and `oob_err` pulses. The read returns 0 with vld=1 and `oob_err` pulses again. Location (1,2) is unchanged.
- Request issued during CLEAR at cycle 10 → no vld, no `oob_err`, and the memory is unaffected after the sweep.
- Write 18'h3FFFF at (6,6) in READY, then pulse `rst` → `mem_ready` drops for 64 cycles, and a read of (6,6) afterwards returns 0.
